// File: rtl/id_forward_issue.sv
// id_forward_issue: register file, full operand bypass, load-use stall
// detection and the registered ID/EXE issue slot.
module id_forward_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  Valid_IN,
  input  logic [REG_ADDR_W-1:0] RegisterRS_IN,
  input  logic [REG_ADDR_W-1:0] RegisterRT_IN,
  input  logic                  UsesRS_IN,
  input  logic                  UsesRT_IN,
  input  logic [REG_ADDR_W-1:0] DestRegister_IN,
  input  logic                  RegWrite_IN,
  input  logic                  MemRead_IN,
  input  logic                  Flush_IN,
  input  logic [DATA_WIDTH-1:0] ExeResult_IN,
  input  logic [DATA_WIDTH-1:0] MemResult_IN,
  input  logic [DATA_WIDTH-1:0] WriteData_IN,
  input  logic [REG_ADDR_W-1:0] WriteRegister_IN,
  input  logic                  WriteEnable_IN,
  output logic                  Stall_OUT,
  output logic                  IssueValid_OUT,
  output logic [DATA_WIDTH-1:0] OperandA_OUT,
  output logic [DATA_WIDTH-1:0] OperandB_OUT,
  output logic [REG_ADDR_W-1:0] WriteRegister_OUT,
  output logic                  WriteEnable_OUT,
  output logic                  MemRead_OUT
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  // Register file read view; entry 0 is the hardwired zero register.
  logic [DATA_WIDTH-1:0] rf_rd [NUM_REGS];
  assign rf_rd[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_rf
      logic [DATA_WIDTH-1:0] reg_q;
      // Register gi captures the WB write addressed to it.
      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
          reg_q <= '0;
        end else if (WriteEnable_IN && (WriteRegister_IN == REG_ADDR_W'(gi))) begin
          reg_q <= WriteData_IN;
        end
      end
      assign rf_rd[gi] = reg_q;
    end
  endgenerate

  // Issue slot state; the slot itself doubles as the EXE shadow.
  logic                  issue_valid_q, issue_valid_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [REG_ADDR_W-1:0] wr_q, wr_d;
  logic                  we_q, we_d;
  logic                  mr_q, mr_d;

  // MEM shadow: the EXE shadow one cycle later. Its load flag never
  // matters because MEM results are always forwardable.
  logic [REG_ADDR_W-1:0] mem_wr_q;
  logic                  mem_we_q;

  logic stall;
  logic bubble;
  logic exe_fwd_ok;

  // A load in EXE cannot supply its data yet; only non-load writers bypass.
  assign exe_fwd_ok = we_q && !mr_q;

  // Youngest-first operand selection for one source index.
  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [DATA_WIDTH-1:0] rf_val
  );
    logic [DATA_WIDTH-1:0] val;
    if (idx == '0) begin
      val = '0;
    end else if (exe_fwd_ok && (wr_q == idx)) begin
      val = ExeResult_IN;
    end else if (mem_we_q && (mem_wr_q == idx)) begin
      val = MemResult_IN;
    end else if (WriteEnable_IN && (WriteRegister_IN == idx)) begin
      val = WriteData_IN;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // Load-use hazard: a consumer directly behind a load must wait one cycle.
  always_comb begin
    stall = 1'b0;
    if (Valid_IN && !Flush_IN && mr_q && we_q && (wr_q != '0)) begin
      stall = (UsesRS_IN && (RegisterRS_IN == wr_q)) ||
              (UsesRT_IN && (RegisterRT_IN == wr_q));
    end
  end

  assign Stall_OUT = stall;

  // Next issue slot: a bubble keeps operands/destination and clears the flags.
  always_comb begin
    bubble        = Flush_IN || stall || !Valid_IN;
    issue_valid_d = 1'b0;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    wr_d          = wr_q;
    we_d          = 1'b0;
    mr_d          = 1'b0;
    if (!bubble) begin
      issue_valid_d = 1'b1;
      op_a_d        = select_operand(RegisterRS_IN, rf_rd[RegisterRS_IN]);
      op_b_d        = select_operand(RegisterRT_IN, rf_rd[RegisterRT_IN]);
      wr_d          = DestRegister_IN;
      we_d          = RegWrite_IN && (DestRegister_IN != '0);
      mr_d          = MemRead_IN;
    end
  end

  // Issue slot and MEM shadow registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      issue_valid_q <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      wr_q          <= '0;
      we_q          <= 1'b0;
      mr_q          <= 1'b0;
      mem_wr_q      <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      wr_q          <= wr_d;
      we_q          <= we_d;
      mr_q          <= mr_d;
      mem_wr_q      <= wr_q;
      mem_we_q      <= we_q;
    end
  end

  assign IssueValid_OUT    = issue_valid_q;
  assign OperandA_OUT      = op_a_q;
  assign OperandB_OUT      = op_b_q;
  assign WriteRegister_OUT = wr_q;
  assign WriteEnable_OUT   = we_q;
  assign MemRead_OUT       = mr_q;

endmodule

// File: tb/tb_id_forward_issue.sv
// Bench for id_forward_issue: directed scenarios with literal expectations
// plus a pipeline-level model compared against the DUT every cycle.
module tb_id_forward_issue;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          Valid_IN = 1'b0;
  logic [AW-1:0] RegisterRS_IN = '0;
  logic [AW-1:0] RegisterRT_IN = '0;
  logic          UsesRS_IN = 1'b0;
  logic          UsesRT_IN = 1'b0;
  logic [AW-1:0] DestRegister_IN = '0;
  logic          RegWrite_IN = 1'b0;
  logic          MemRead_IN = 1'b0;
  logic          Flush_IN = 1'b0;
  logic [DW-1:0] ExeResult_IN = '0;
  logic [DW-1:0] MemResult_IN = '0;
  logic [DW-1:0] WriteData_IN = '0;
  logic [AW-1:0] WriteRegister_IN = '0;
  logic          WriteEnable_IN = 1'b0;
  logic          Stall_OUT;
  logic          IssueValid_OUT;
  logic [DW-1:0] OperandA_OUT;
  logic [DW-1:0] OperandB_OUT;
  logic [AW-1:0] WriteRegister_OUT;
  logic          WriteEnable_OUT;
  logic          MemRead_OUT;

  id_forward_issue #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Valid_IN(Valid_IN),
    .RegisterRS_IN(RegisterRS_IN), .RegisterRT_IN(RegisterRT_IN),
    .UsesRS_IN(UsesRS_IN), .UsesRT_IN(UsesRT_IN),
    .DestRegister_IN(DestRegister_IN), .RegWrite_IN(RegWrite_IN),
    .MemRead_IN(MemRead_IN), .Flush_IN(Flush_IN),
    .ExeResult_IN(ExeResult_IN), .MemResult_IN(MemResult_IN),
    .WriteData_IN(WriteData_IN), .WriteRegister_IN(WriteRegister_IN),
    .WriteEnable_IN(WriteEnable_IN), .Stall_OUT(Stall_OUT),
    .IssueValid_OUT(IssueValid_OUT), .OperandA_OUT(OperandA_OUT),
    .OperandB_OUT(OperandB_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .WriteEnable_OUT(WriteEnable_OUT), .MemRead_OUT(MemRead_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // In-flight instructions, youngest first: [0] is in EXE, [1] is in MEM.
  typedef struct { bit we; bit ld; int dest; } rec_t;
  rec_t          pipe[$];
  logic [DW-1:0] m_rf [NR];
  logic          m_iv;
  logic [DW-1:0] m_opa, m_opb;
  logic [AW-1:0] m_wr;
  logic          m_we, m_mr;

  function automatic bit exp_stall();
    if (pipe.size() != 2) return 1'b0;
    if (!Valid_IN || Flush_IN) return 1'b0;
    if (!(pipe[0].ld && pipe[0].we && pipe[0].dest != 0)) return 1'b0;
    return (UsesRS_IN && int'(RegisterRS_IN) == pipe[0].dest) ||
           (UsesRT_IN && int'(RegisterRT_IN) == pipe[0].dest);
  endfunction

  // Value a reader of idx must see: youngest producer whose data is available.
  function automatic logic [DW-1:0] m_operand(input int idx);
    if (idx == 0) return '0;
    for (int age = 0; age < 2; age++) begin
      if (pipe[age].we && pipe[age].dest == idx) begin
        if (age == 0 && !pipe[age].ld) return ExeResult_IN;
        if (age == 1) return MemResult_IN;
      end
    end
    if (WriteEnable_IN && int'(WriteRegister_IN) == idx) return WriteData_IN;
    return m_rf[idx];
  endfunction

  always @(posedge CLOCK or posedge RESET) begin : model
    rec_t          r;
    bit            bub;
    logic [DW-1:0] a, b;
    if (RESET) begin
      pipe.delete();
      r.we = 0; r.ld = 0; r.dest = 0;
      pipe.push_back(r);
      pipe.push_back(r);
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      m_iv = 0; m_opa = '0; m_opb = '0; m_wr = '0; m_we = 0; m_mr = 0;
    end else begin
      bub = Flush_IN || exp_stall() || !Valid_IN;
      a = m_operand(int'(RegisterRS_IN));
      b = m_operand(int'(RegisterRT_IN));
      if (WriteEnable_IN && WriteRegister_IN != 0) m_rf[WriteRegister_IN] = WriteData_IN;
      r.we   = !bub && RegWrite_IN && DestRegister_IN != 0;
      r.ld   = !bub && MemRead_IN;
      r.dest = bub ? int'(m_wr) : int'(DestRegister_IN);
      pipe.push_front(r);
      void'(pipe.pop_back());
      m_iv = !bub;
      m_we = r.we;
      m_mr = r.ld;
      if (!bub) begin
        m_opa = a; m_opb = b; m_wr = DestRegister_IN;
      end
    end
  end

  // Compare process: every cycle out of reset, mid-cycle.
  always @(negedge CLOCK) begin
    if (!RESET && pipe.size() == 2) begin
      check("cmp_stall", Stall_OUT, exp_stall());
      check("cmp_iv", IssueValid_OUT, m_iv);
      check("cmp_opa", OperandA_OUT, m_opa);
      check("cmp_opb", OperandB_OUT, m_opb);
      check("cmp_wr", WriteRegister_OUT, m_wr);
      check("cmp_we", WriteEnable_OUT, m_we);
      check("cmp_mr", MemRead_OUT, m_mr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic step(input string name);
    cyc();
    $display("txn %-10s iv=%0d a=%08h b=%08h wr=%0d we=%0d mr=%0d", name,
             IssueValid_OUT, OperandA_OUT, OperandB_OUT, WriteRegister_OUT,
             WriteEnable_OUT, MemRead_OUT);
  endtask

  task automatic set_instr(input bit v, input int rs, input int rt, input bit urs,
                           input bit urt, input int dest, input bit rw, input bit mr,
                           input bit fl);
    Valid_IN = v; RegisterRS_IN = AW'(rs); RegisterRT_IN = AW'(rt);
    UsesRS_IN = urs; UsesRT_IN = urt; DestRegister_IN = AW'(dest);
    RegWrite_IN = rw; MemRead_IN = mr; Flush_IN = fl;
  endtask

  task automatic wb(input bit we, input int wr, input logic [DW-1:0] wd);
    WriteEnable_IN = we; WriteRegister_IN = AW'(wr); WriteData_IN = wd;
  endtask

  initial begin
    bit st_prev;
    cyc(); cyc();
    RESET = 1'b0;
    check("rst_iv", IssueValid_OUT, 0);
    check("rst_opa", OperandA_OUT, 0);
    check("rst_we", WriteEnable_OUT, 0);

    // Fill r5 so that a later reset has something to clear.
    wb(1, 5, 32'h5555); set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wr_r5");

    // WB write-through: read r3 while WB writes it.
    wb(1, 3, 32'h11); set_instr(1, 3, 0, 1, 0, 7, 1, 0, 0);
    #1 check("wt_stall", Stall_OUT, 0);
    step("wt_r3");
    check("wt_opa", OperandA_OUT, 32'h11);
    check("wt_iv", IssueValid_OUT, 1);

    // ALU r4 then direct reader of r4 forwarded from EXE.
    wb(0, 0, 0); set_instr(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step("alu_r4");
    ExeResult_IN = 32'hABCD; set_instr(1, 4, 0, 1, 0, 8, 1, 0, 0);
    #1 check("exe_stall", Stall_OUT, 0);
    step("use_r4");
    check("exe_opa", OperandA_OUT, 32'hABCD);

    // Load r6 then reader of RT=r6: one stall, one bubble, then MEM forward.
    set_instr(1, 0, 0, 0, 0, 6, 1, 1, 0);
    step("ld_r6");
    check("ld_mr", MemRead_OUT, 1);
    set_instr(1, 0, 6, 0, 1, 9, 1, 0, 0);
    #1 check("lu_stall", Stall_OUT, 1);
    step("lu_bubble");
    check("lu_iv", IssueValid_OUT, 0);
    check("lu_stall_end", Stall_OUT, 0);
    MemResult_IN = 32'h55;
    step("use_r6");
    check("lu_opb", OperandB_OUT, 32'h55);
    check("lu_iv2", IssueValid_OUT, 1);

    // Load-use pair where the consumer is flushed.
    set_instr(1, 0, 0, 0, 0, 9, 1, 1, 0);
    step("ld_r9");
    set_instr(1, 9, 0, 1, 0, 10, 1, 0, 1);
    #1 check("fl_stall", Stall_OUT, 0);
    step("flush");
    check("fl_iv", IssueValid_OUT, 0);
    check("fl_we", WriteEnable_OUT, 0);

    // Destination r0 never writes; WB to r0 is ignored.
    wb(1, 0, 32'hFFFF); set_instr(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step("dest_r0");
    check("r0_we", WriteEnable_OUT, 0);
    check("r0_iv", IssueValid_OUT, 1);
    wb(0, 0, 0); set_instr(1, 0, 0, 1, 1, 12, 1, 0, 0);
    step("read_r0");
    check("r0_opa", OperandA_OUT, 0);
    check("r0_opb", OperandB_OUT, 0);

    // EXE beats WB on the same register; RS==RT both get it.
    set_instr(1, 0, 0, 0, 0, 11, 1, 0, 0);
    step("alu_r11");
    ExeResult_IN = 32'h99; wb(1, 11, 32'h77); set_instr(1, 11, 11, 1, 1, 13, 1, 0, 0);
    step("use_r11");
    check("prio_opa", OperandA_OUT, 32'h99);
    check("prio_opb", OperandB_OUT, 32'h99);
    wb(0, 0, 0);

    // Reset in the middle of a stall.
    set_instr(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step("ld_r2");
    set_instr(1, 2, 0, 1, 0, 14, 1, 0, 0);
    #1 check("mr_stall", Stall_OUT, 1);
    RESET = 1'b1;
    #1;
    check("mr_stall0", Stall_OUT, 0);
    check("mr_iv", IssueValid_OUT, 0);
    check("mr_opa", OperandA_OUT, 0);
    check("mr_opb", OperandB_OUT, 0);
    check("mr_wr", WriteRegister_OUT, 0);
    check("mr_we", WriteEnable_OUT, 0);
    check("mr_mr", MemRead_OUT, 0);
    cyc();
    RESET = 1'b0;
    set_instr(1, 5, 0, 1, 0, 15, 1, 0, 0);
    step("read_r5");
    check("rst_r5", OperandA_OUT, 0);
    check("rst_iv2", IssueValid_OUT, 1);

    // Dense mix on r0..r7 checked only by the compare process.
    st_prev = 0;
    for (int n = 0; n < 300; n++) begin
      if (!st_prev) begin
        set_instr($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
      end
      ExeResult_IN = $urandom;
      MemResult_IN = $urandom;
      wb($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      #1 st_prev = exp_stall();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
